// File: rtl/sr_row_feeder_pkg.sv
// Shared types and constants for the SR row feeder: pixel/row/window shapes,
// counter widths, FSM states and the offset clamp helper.
package sr_row_feeder_pkg;

  localparam int DATAWIDTH   = 8;
  localparam int ROW_PIXELS  = 16;
  localparam int WIN_PIXELS  = 8;
  localparam int NUM_ROWS    = 8;
  localparam int READ_CYCLES = 50;
  localparam int MAX_OFFSET  = 8;
  localparam int OFF_W       = 4;
  localparam int ADDR_W      = 4;
  localparam int ISSUE_W     = $clog2(NUM_ROWS + 1);
  localparam int ROWCNT_W    = $clog2(NUM_ROWS);
  localparam int READ_W      = $clog2(READ_CYCLES);

  typedef logic [ROW_PIXELS-1:0][DATAWIDTH-1:0] row_t;
  typedef logic [WIN_PIXELS-1:0][DATAWIDTH-1:0] win_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_DONE
  } state_t;

  // Offsets above MAX_OFFSET would push the window or row range past the block edge.
  function automatic logic [OFF_W-1:0] clamp_offset(input logic [OFF_W-1:0] off);
    return (off > OFF_W'(MAX_OFFSET)) ? OFF_W'(MAX_OFFSET) : off;
  endfunction

endpackage

// File: rtl/sr_row_feeder_if.sv
// Row-memory read port plus the row/window bus towards the FME shift register.
interface sr_row_feeder_if;
  import sr_row_feeder_pkg::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  row_t              mem_rdata;
  logic              stall;
  win_t              win;
  logic              sr_enable;
  logic              sr_enable_read;

  modport master (
    output mem_en, mem_addr, win, sr_enable, sr_enable_read,
    input  mem_rdata, stall
  );

  modport slave (
    input  mem_en, mem_addr, win, sr_enable, sr_enable_read,
    output mem_rdata, stall
  );

endinterface

// File: rtl/sr_row_feeder_window_sel.sv
// Combinational 16->8 pixel window mux: win_o[k] = row_i[col_offset_i + k].
module sr_row_feeder_window_sel
  import sr_row_feeder_pkg::*;
(
  input  row_t             row_i,
  input  logic [OFF_W-1:0] col_offset_i,
  output win_t             win_o
);

  // col_offset_i is already clamped, so col+k never exceeds the last pixel.
  for (genvar gi = 0; gi < WIN_PIXELS; gi++) begin : g_pix
    logic [OFF_W-1:0] idx;
    assign idx       = col_offset_i + OFF_W'(gi);
    assign win_o[gi] = row_i[idx];
  end

endmodule

// File: rtl/sr_row_feeder.sv
// Streams NUM_ROWS windowed rows from the row memory to the SR interface,
// then holds the read phase for READ_CYCLES cycles and pulses done.
module sr_row_feeder
  import sr_row_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [OFF_W-1:0] col_offset_i,
  input  logic [OFF_W-1:0] row_offset_i,
  output logic             busy_o,
  output logic             done_o,
  sr_row_feeder_if.master  bus
);

  state_t              state_q;
  logic [OFF_W-1:0]    col_q;
  logic [OFF_W-1:0]    row_q;
  logic [ISSUE_W-1:0]  issue_cnt_q;
  logic [ROWCNT_W-1:0] row_cnt_q;
  logic [READ_W-1:0]   read_cnt_q;
  logic                inflight_q;
  logic                skid_v_q;
  win_t                skid_q;
  win_t                out_q;
  logic                sr_en_q;
  logic                sr_rd_q;
  logic                busy_q;
  logic                done_q;

  win_t                arr_win;
  logic                issue;
  logic                consume;

  sr_row_feeder_window_sel u_sel (
    .row_i        (bus.mem_rdata),
    .col_offset_i (col_q),
    .win_o        (arr_win)
  );

  // Stall gates both the read strobe and the row strobe in the same cycle, so at
  // most one read can land while stalled and a single skid entry suffices.
  assign issue   = (state_q == ST_FETCH) && (issue_cnt_q != ISSUE_W'(NUM_ROWS)) && !bus.stall;
  assign consume = sr_en_q && !bus.stall;

  assign bus.mem_en         = issue;
  assign bus.mem_addr       = row_q + ADDR_W'(issue_cnt_q);
  assign bus.win            = out_q;
  assign bus.sr_enable      = consume;
  assign bus.sr_enable_read = sr_rd_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      issue_cnt_q <= '0;
      row_cnt_q   <= '0;
      read_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_q      <= '0;
      out_q       <= '0;
      sr_en_q     <= 1'b0;
      sr_rd_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q     <= ST_FETCH;
            busy_q      <= 1'b1;
            col_q       <= clamp_offset(col_offset_i);
            row_q       <= clamp_offset(row_offset_i);
            issue_cnt_q <= '0;
            row_cnt_q   <= '0;
            read_cnt_q  <= '0;
            skid_v_q    <= 1'b0;
            sr_en_q     <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
          if (!bus.stall) begin
            // The pending row (if any) is taken this cycle; refill skid entry first.
            if (skid_v_q) begin
              out_q    <= skid_q;
              sr_en_q  <= 1'b1;
              skid_v_q <= inflight_q;
              if (inflight_q) begin
                skid_q <= arr_win;
              end
            end else if (inflight_q) begin
              out_q   <= arr_win;
              sr_en_q <= 1'b1;
            end else begin
              sr_en_q <= 1'b0;
            end
            if (consume) begin
              if (row_cnt_q == ROWCNT_W'(NUM_ROWS - 1)) begin
                state_q    <= ST_READ;
                sr_rd_q    <= 1'b1;
                read_cnt_q <= '0;
                sr_en_q    <= 1'b0;
              end else begin
                row_cnt_q <= row_cnt_q + 1'b1;
              end
            end
          end else if (inflight_q) begin
            skid_q   <= arr_win;
            skid_v_q <= 1'b1;
          end
        end

        ST_READ: begin
          if (read_cnt_q == READ_W'(READ_CYCLES - 1)) begin
            state_q <= ST_DONE;
            sr_rd_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            read_cnt_q <= read_cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_row_feeder.sv
// Directed scoreboard bench for sr_row_feeder against a preloaded row memory
// where pixel(r,c) = 16*r + c.
module tb_sr_row_feeder;
  import sr_row_feeder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [3:0] col_offset_i;
  logic [3:0] row_offset_i;
  logic       busy_o;
  logic       done_o;

  sr_row_feeder_if bus ();

  sr_row_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .col_offset_i (col_offset_i),
    .row_offset_i (row_offset_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  row_t mem [16];
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int   checks = 0;
  int   errors = 0;
  win_t sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic push_rows(input int col, input int row);
    int   cc;
    int   rr;
    win_t w;
    cc = clampi(col);
    rr = clampi(row);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) w[k] = 8'(16 * (rr + i) + cc + k);
      sb_q.push_back(w);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sr_enable"}, 64'(bus.sr_enable), 64'd0);
    chk({tag, "_sr_enable_read"}, 64'(bus.sr_enable_read), 64'd0);
    chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_win"}, bus.win, 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  // One full transaction: start at relative cycle 0, optional stall window and
  // optional second start pulse, then timing checks relative to the expected last row.
  task automatic run_op(input int col, input int row, input int stall_at, input int stall_len,
                        input int restart_at, input int exp_first, input int exp_last);
    int   en_cnt = 0, rd_cnt = 0, done_cnt = 0, post = 0;
    int   first_en = -1, last_en = -1, first_rd = -1, last_rd = -1, done_k = -1;
    bit   done_seen = 0;
    bit   stl;
    win_t exp_w;
    push_rows(col, row);
    @(posedge clk); #1;
    col_offset_i = 4'(col);
    row_offset_i = 4'(row);
    start_i = 1'b1;
    for (int k = 1; k <= 150 && post < 3; k++) begin
      @(posedge clk); #1;
      start_i = (k == restart_at);
      stl = (stall_at >= 0 && k >= stall_at && k < stall_at + stall_len);
      bus.stall = stl;
      if (k == 2) begin
        col_offset_i = 4'd3;
        row_offset_i = 4'd1;
      end
      @(negedge clk);
      if (k == 1) begin
        chk("busy_first", 64'(busy_o), 64'd1);
        chk("mem_en_first", 64'(bus.mem_en), 64'd1);
        chk("mem_addr_first", 64'(bus.mem_addr), 64'(clampi(row)));
      end
      if (stl) begin
        chk("stall_sr_enable", 64'(bus.sr_enable), 64'd0);
        chk("stall_mem_en", 64'(bus.mem_en), 64'd0);
      end
      if (bus.sr_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
        if (sb_q.size() > 0) begin
          exp_w = sb_q.pop_front();
          chk("row_window", bus.win, exp_w);
        end else begin
          chk("row_extra_count", 64'(en_cnt), 64'd8);
        end
      end
      if (bus.sr_enable_read) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      if (done_seen) begin
        post++;
        chk("busy_after_done", 64'(busy_o), 64'd0);
        chk("sr_enable_after_done", 64'(bus.sr_enable), 64'd0);
      end
      if (done_o) begin
        done_cnt++;
        done_k = k;
        done_seen = 1;
        chk("busy_at_done", 64'(busy_o), 64'd0);
      end
    end
    start_i = 1'b0;
    bus.stall = 1'b0;
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("row_count", 64'(en_cnt), 64'd8);
    chk("first_row_cycle", 64'(first_en), 64'(exp_first));
    chk("last_row_cycle", 64'(last_en), 64'(exp_last));
    chk("read_first_cycle", 64'(first_rd), 64'(exp_last + 1));
    chk("read_last_cycle", 64'(last_rd), 64'(exp_last + READ_CYCLES));
    chk("read_count", 64'(rd_cnt), 64'(READ_CYCLES));
    chk("done_cycle", 64'(done_k), 64'(exp_last + READ_CYCLES + 1));
    chk("scoreboard_left", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    $display("txn col=%0d row=%0d stall_at=%0d len=%0d rows=%0d first=%0d last=%0d done=%0d",
             col, row, stall_at, stall_len, en_cnt, first_en, last_en, done_k);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    col_offset_i = 4'd0;
    row_offset_i = 4'd0;
    bus.stall = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = 8'(16 * r + c);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(4, 0, -1, 0, -1, 3, 10);     // basic stream
    run_op(12, 15, -1, 0, -1, 3, 10);   // both offsets clamp to 8
    run_op(4, 0, 5, 3, -1, 3, 13);      // mid-stream stall, skid path
    run_op(4, 0, 2, 2, -1, 5, 12);      // stall before first row lands
    run_op(4, 0, -1, 0, 6, 3, 10);      // start while busy
    run_op(0, 8, -1, 0, -1, 3, 10);     // lowest column, last rows of block
    run_op(2, 3, 20, 5, 61, 3, 10);     // stall in READ, start coincident with done
    run_op(8, 8, -1, 0, -1, 3, 10);     // exact upper legal offsets

    // Asynchronous reset mid-stream, then a clean rerun.
    @(posedge clk); #1;
    col_offset_i = 4'd4;
    row_offset_i = 4'd0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("txn async reset mid-stream at cycle %0d", cyc);
    run_op(4, 0, -1, 0, -1, 3, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
